// File: rtl/pe_mult_ctrl.sv
// Sequencer for the 32-lane int16 multiply datapath. It walks out_num dot products
// of in_beats beats, aligns accumulator strobes with buffer data, and writes one result per neuron.
module pe_mult_ctrl #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_in_beats,
  input  logic [CNT_W-1:0]  cfg_out_num,
  input  logic [ADDR_W-1:0] cfg_neuron_base,
  input  logic [ADDR_W-1:0] cfg_weight_base,
  input  logic [ADDR_W-1:0] cfg_result_base,
  input  logic              hold,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_addr,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_addr,
  output logic              mult_vld,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              acc_last,
  output logic              result_wr_en,
  output logic [ADDR_W-1:0] result_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]  r_in_beats;
  logic [CNT_W-1:0]  r_out_num;
  logic [ADDR_W-1:0] r_neuron_base;
  logic [ADDR_W-1:0] r_result_base;
  logic [CNT_W-1:0]  r_beat;
  logic [CNT_W-1:0]  r_out;
  logic [ADDR_W-1:0] r_wptr;
  logic              r_drain_cnt;

  logic              r_s1_vld;
  logic              r_s1_first;
  logic              r_s1_last;
  logic [CNT_W-1:0]  r_s1_out;
  logic              r_s2_wr;
  logic [ADDR_W-1:0] r_s2_addr;

  logic w_cfg_ok;
  logic w_accept;
  logic w_issue;
  logic w_beat_last;
  logic w_out_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    w_cfg_ok     = (cfg_in_beats != '0) && (cfg_out_num != '0);
    w_beat_last  = (r_beat == r_in_beats - CNT_W'(1));
    w_out_last   = (r_out == r_out_num - CNT_W'(1));

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = w_cfg_ok;
          w_state_next = w_cfg_ok ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          w_issue = 1'b1;
          if (w_beat_last && w_out_last) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt) w_state_next = S_DONE;
      end
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // NOTE: read strobes are combinational from state, so rst gates them directly to
    // keep the buffers quiet in the very cycle reset is asserted.
    nram_rd_en   = w_issue && !rst;
    wram_rd_en   = w_issue && !rst;
    nram_addr    = nram_rd_en ? r_neuron_base + ADDR_W'(r_beat) : '0;
    wram_addr    = wram_rd_en ? r_wptr : '0;
    mult_vld     = r_s1_vld;
    acc_en       = r_s1_vld;
    acc_clear    = r_s1_vld && r_s1_first;
    acc_last     = r_s1_vld && r_s1_last;
    result_wr_en = r_s2_wr;
    result_addr  = r_s2_addr;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_beats    <= '0;
      r_out_num     <= '0;
      r_neuron_base <= '0;
      r_result_base <= '0;
      r_beat        <= '0;
      r_out         <= '0;
      r_wptr        <= '0;
      r_drain_cnt   <= 1'b0;
      r_s1_vld      <= 1'b0;
      r_s1_first    <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_out      <= '0;
      r_s2_wr       <= 1'b0;
      r_s2_addr     <= '0;
    end else begin
      r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;

      if (w_accept) begin
        r_in_beats    <= cfg_in_beats;
        r_out_num     <= cfg_out_num;
        r_neuron_base <= cfg_neuron_base;
        r_result_base <= cfg_result_base;
        r_beat        <= '0;
        r_out         <= '0;
        r_wptr        <= cfg_weight_base;
      end else if (w_issue) begin
        // Weight address is a running pointer: out*in_beats+beat advances by one per beat.
        r_wptr <= r_wptr + ADDR_W'(1);
        if (w_beat_last) begin
          r_beat <= '0;
          r_out  <= r_out + CNT_W'(1);
        end else begin
          r_beat <= r_beat + CNT_W'(1);
        end
      end

      // One-cycle read latency: beat tags travel alongside the buffer data.
      r_s1_vld   <= w_issue;
      r_s1_first <= w_issue && (r_beat == '0);
      r_s1_last  <= w_issue && w_beat_last;
      r_s1_out   <= r_out;

      r_s2_wr   <= r_s1_vld && r_s1_last;
      r_s2_addr <= (r_s1_vld && r_s1_last) ? r_result_base + ADDR_W'(r_s1_out) : '0;
    end
  end

endmodule

// File: tb/tb_pe_mult_ctrl.sv
// Scoreboard bench for pe_mult_ctrl: a reference model queues expected reads,
// accumulator strobes and result writes; a negedge monitor pops and compares them.
module tb_pe_mult_ctrl;

  localparam int AW = 8;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_in_beats;
  logic [CW-1:0] cfg_out_num;
  logic [AW-1:0] cfg_neuron_base;
  logic [AW-1:0] cfg_weight_base;
  logic [AW-1:0] cfg_result_base;
  logic          hold;
  logic          nram_rd_en;
  logic [AW-1:0] nram_addr;
  logic          wram_rd_en;
  logic [AW-1:0] wram_addr;
  logic          mult_vld;
  logic          acc_clear;
  logic          acc_en;
  logic          acc_last;
  logic          result_wr_en;
  logic [AW-1:0] result_addr;
  logic          busy;
  logic          done;

  pe_mult_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_in_beats    (cfg_in_beats),
    .cfg_out_num     (cfg_out_num),
    .cfg_neuron_base (cfg_neuron_base),
    .cfg_weight_base (cfg_weight_base),
    .cfg_result_base (cfg_result_base),
    .hold            (hold),
    .nram_rd_en      (nram_rd_en),
    .nram_addr       (nram_addr),
    .wram_rd_en      (wram_rd_en),
    .wram_addr       (wram_addr),
    .mult_vld        (mult_vld),
    .acc_clear       (acc_clear),
    .acc_en          (acc_en),
    .acc_last        (acc_last),
    .result_wr_en    (result_wr_en),
    .result_addr     (result_addr),
    .busy            (busy),
    .done            (done)
  );

  typedef struct packed {
    logic [AW-1:0] n;
    logic [AW-1:0] w;
  } rd_t;

  rd_t           rd_q[$];
  logic [1:0]    acc_q[$];
  logic [AW-1:0] wr_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Monitor: every read, accumulate beat and result write must match the queue head.
  rd_t           m_rd;
  logic [1:0]    m_acc;
  logic [AW-1:0] m_wr;

  always @(negedge clk) begin
    if (nram_rd_en || wram_rd_en) begin
      n_checks++;
      if (!(nram_rd_en && wram_rd_en)) begin
        n_errors++;
        $display("FAIL rd_en_pair: nram_rd_en=%0b wram_rd_en=%0b, required both 1", nram_rd_en, wram_rd_en);
      end
      n_checks++;
      if (rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL read_unexpected: nram=%h wram=%h at cycle %0d, required no read", nram_addr, wram_addr, cyc);
      end else begin
        m_rd = rd_q.pop_front();
        if ({nram_addr, wram_addr} !== {m_rd.n, m_rd.w}) begin
          n_errors++;
          $display("FAIL read_addr: nram=%h wram=%h, required nram=%h wram=%h", nram_addr, wram_addr, m_rd.n, m_rd.w);
        end
      end
    end

    if (mult_vld) begin
      n_checks++;
      if (acc_q.size() == 0) begin
        n_errors++;
        $display("FAIL acc_unexpected: mult_vld=1 at cycle %0d, required 0", cyc);
      end else begin
        m_acc = acc_q.pop_front();
        if ({acc_en, acc_clear, acc_last} !== {1'b1, m_acc}) begin
          n_errors++;
          $display("FAIL acc_strobes: en/clear/last=%b, required %b", {acc_en, acc_clear, acc_last}, {1'b1, m_acc});
        end
      end
    end else if (acc_en || acc_clear || acc_last) begin
      n_checks++;
      n_errors++;
      $display("FAIL acc_without_vld: en/clear/last=%b, required 000", {acc_en, acc_clear, acc_last});
    end

    if (result_wr_en) begin
      n_checks++;
      if (wr_q.size() == 0) begin
        n_errors++;
        $display("FAIL write_unexpected: result_addr=%h at cycle %0d, required no write", result_addr, cyc);
      end else begin
        m_wr = wr_q.pop_front();
        if (result_addr !== m_wr) begin
          n_errors++;
          $display("FAIL result_addr: got %h, required %h", result_addr, m_wr);
        end
      end
    end
  end

  // Reference model: uses a real multiply for the weight offset.
  task automatic push_op(input logic [CW-1:0] in_b, input logic [CW-1:0] out_n,
                         input logic [AW-1:0] nb, input logic [AW-1:0] wb, input logic [AW-1:0] rb);
    rd_t r;
    for (int o = 0; o < int'(out_n); o++) begin
      for (int b = 0; b < int'(in_b); b++) begin
        r.n = nb + AW'(b);
        r.w = wb + AW'(o * int'(in_b)) + AW'(b);
        rd_q.push_back(r);
        acc_q.push_back({b == 0, b == int'(in_b) - 1});
        if (b == int'(in_b) - 1) wr_q.push_back(rb + AW'(o));
      end
    end
  endtask

  task automatic start_op(input logic [CW-1:0] in_b, input logic [CW-1:0] out_n,
                          input logic [AW-1:0] nb, input logic [AW-1:0] wb,
                          input logic [AW-1:0] rb, output int c0);
    @(posedge clk);
    #1;
    start           = 1'b1;
    cfg_in_beats    = in_b;
    cfg_out_num     = out_n;
    cfg_neuron_base = nb;
    cfg_weight_base = wb;
    cfg_result_base = rb;
    c0              = cyc;
    if (in_b != 0 && out_n != 0) push_op(in_b, out_n, nb, wb, rb);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done; reports its offset from the start cycle (-1 on timeout) and a mult_vld map.
  task automatic wait_done(input int c0, output int off, output logic [31:0] vmask);
    vmask = '0;
    off   = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (mult_vld && (cyc - c0) < 32) vmask[cyc - c0] = 1'b1;
      if (done) begin
        off = cyc - c0;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input int off, input int exp_off,
                          input logic [31:0] vmask, input logic [31:0] exp_mask);
    n_checks++;
    if (off !== exp_off) begin
      n_errors++;
      $display("FAIL %s_done_cycle: got %0d, required %0d", name, off, exp_off);
    end
    n_checks++;
    if (vmask !== exp_mask) begin
      n_errors++;
      $display("FAIL %s_vld_map: got %h, required %h", name, vmask, exp_mask);
    end
    @(negedge clk);
    n_checks++;
    if (rd_q.size() != 0 || acc_q.size() != 0 || wr_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drained: left rd=%0d acc=%0d wr=%0d, required 0/0/0", name, rd_q.size(), acc_q.size(), wr_q.size());
    end
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_errors++;
      $display("FAIL %s_idle_after: busy/done=%b, required 00", name, {busy, done});
    end
  endtask

  function automatic logic [48:0] all_outs();
    return {nram_rd_en, nram_addr, wram_rd_en, wram_addr, mult_vld, acc_clear, acc_en,
            acc_last, result_wr_en, result_addr, busy, done};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (all_outs() !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs());
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int c0, off;
    logic [31:0] vm;
    start_op(8'd4, 8'd2, 8'h10, 8'h40, 8'h80, c0);
    wait_done(c0, off, vm);
    check_op("basic", off, 11, vm, 32'h0000_03FC);
  endtask

  task automatic test_single_beat();
    int c0, off;
    logic [31:0] vm;
    start_op(8'd1, 8'd3, 8'h20, 8'h30, 8'h50, c0);
    wait_done(c0, off, vm);
    check_op("single", off, 6, vm, 32'h0000_001C);
  endtask

  task automatic test_zero_cfg();
    int c0, off;
    logic [31:0] vm;
    start_op(8'd4, 8'd0, 8'h10, 8'h40, 8'h80, c0);
    wait_done(c0, off, vm);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_busy_in_done: got %b, required 1", busy);
    end
    check_op("zero_out", off, 1, vm, 32'h0);
    start_op(8'd0, 8'd5, 8'h10, 8'h40, 8'h80, c0);
    wait_done(c0, off, vm);
    check_op("zero_in", off, 1, vm, 32'h0);
  endtask

  task automatic test_hold();
    int c0, off;
    logic [31:0] vm;
    start_op(8'd4, 8'd1, 8'h00, 8'h60, 8'h90, c0);
    fork
      begin
        @(posedge clk);
        #1 hold = 1'b1;
        repeat (3) @(posedge clk);
        #1 hold = 1'b0;
      end
      wait_done(c0, off, vm);
    join
    check_op("hold", off, 10, vm, 32'h0000_01C4);
  endtask

  task automatic test_wrap();
    int c0, off;
    logic [31:0] vm;
    start_op(8'd4, 8'd1, 8'hFD, 8'hFE, 8'hFF, c0);
    wait_done(c0, off, vm);
    check_op("wrap", off, 7, vm, 32'h0000_003C);
  endtask

  task automatic test_back_to_back();
    int c0, off;
    logic [31:0] vm;
    start_op(8'd2, 8'd2, 8'h01, 8'h02, 8'h03, c0);
    wait_done(c0, off, vm);
    // Start driven in the IDLE cycle right after done.
    start_op(8'd3, 8'd1, 8'h05, 8'h06, 8'h07, c0);
    n_checks++;
    if (c0 !== cyc - 1) begin
      n_errors++;
      $display("FAIL b2b_start_slot: start cycle %0d, required %0d", c0, cyc - 1);
    end
    wait_done(c0, off, vm);
    check_op("b2b", off, 6, vm, 32'h0000_001C);
  endtask

  task automatic test_reset_mid_op();
    int c0, off, stray;
    logic [31:0] vm;
    start_op(8'd4, 8'd2, 8'h10, 8'h40, 8'h80, c0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (rd_q.size() != 6) begin
      n_errors++;
      $display("FAIL rstmid_reads_issued: remaining %0d, required 6", rd_q.size());
    end
    rd_q.delete();
    acc_q.delete();
    wr_q.delete();
    @(negedge clk);
    n_checks++;
    if (all_outs() !== '0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got %h, required 0", all_outs());
    end
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || result_wr_en || busy) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_errors++;
      $display("FAIL rstmid_quiet: %0d active cycles, required 0", stray);
    end
    start_op(8'd4, 8'd2, 8'h10, 8'h40, 8'h80, c0);
    wait_done(c0, off, vm);
    check_op("rstmid_rerun", off, 11, vm, 32'h0000_03FC);
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    hold            = 1'b0;
    cfg_in_beats    = '0;
    cfg_out_num     = '0;
    cfg_neuron_base = '0;
    cfg_weight_base = '0;
    cfg_result_base = '0;

    test_reset();
    test_basic();
    test_single_beat();
    test_zero_cfg();
    test_hold();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
